// File: rtl/mips_pkg.sv
// Shared constants for the MIPS execute stage: ALU operation codes and
// forwarding-mux select encodings.
package mips_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

endpackage

// File: rtl/forwarding_unit.sv
// Combinational RAW-hazard forwarding selects for the EX-stage operands.
// EX/MEM is checked first because it holds the newer value.
module forwarding_unit
    import mips_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_write_reg,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_write_reg,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b
);

    // Register 0 is hardwired, so a pending write to it never forwards.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        if (exmem_reg_write && (exmem_write_reg != '0) && (exmem_write_reg == src))
            return FWD_EXMEM;
        else if (memwb_reg_write && (memwb_write_reg != '0) && (memwb_write_reg == src))
            return FWD_MEMWB;
        else
            return FWD_REG;
    endfunction

    always_comb begin
        forward_a = fwd_sel(rs);
        forward_b = fwd_sel(rt);
    end

endmodule

// File: rtl/ex_mem_stage.sv
// MIPS execute stage: operand forwarding, ALU, destination select and the
// EX/MEM pipeline register feeding the MEM stage.
module ex_mem_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_regWrite_IDEX,
    input  logic              in_ALUSrc_IDEX,
    input  logic              in_regDst_IDEX,
    input  logic              in_memWrite_IDEX,
    input  logic              in_memRead_IDEX,
    input  logic              in_memtoReg_IDEX,
    input  logic [2:0]        in_ALUop_IDEX,
    input  logic [REG_AW-1:0] in_Rs_IDEX,
    input  logic [REG_AW-1:0] in_Rt_IDEX,
    input  logic [REG_AW-1:0] in_Rd_IDEX,
    input  logic [DATA_W-1:0] in_data1_IDEX,
    input  logic [DATA_W-1:0] in_data2_IDEX,
    input  logic [DATA_W-1:0] in_SEData_IDEX,
    input  logic              regWrite_MEMWB,
    input  logic [REG_AW-1:0] writeReg_MEMWB,
    input  logic [DATA_W-1:0] writeData_MEMWB,
    output logic              out_reg_regWrite_EXMEM,
    output logic              out_reg_memWrite_EXMEM,
    output logic              out_reg_memRead_EXMEM,
    output logic              out_reg_memtoReg_EXMEM,
    output logic [DATA_W-1:0] out_reg_ALUres_EXMEM,
    output logic [DATA_W-1:0] out_reg_writeData_EXMEM,
    output logic [REG_AW-1:0] out_reg_writeReg_EXMEM,
    output logic              zero
);

    logic [1:0]               forward_a;
    logic [1:0]               forward_b;
    logic [DATA_W-1:0]        op_a;
    logic [DATA_W-1:0]        fwd_b;
    logic [DATA_W-1:0]        op_b;
    logic [DATA_W-1:0]        alu_res;
    logic [REG_AW-1:0]        write_reg;

    // Arithmetic wraps modulo 2^DATA_W; slt compares as two's complement.
    function automatic logic [DATA_W-1:0] alu_op(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        sa = a;
        sb = b;
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SLT: return (sa < sb) ? DATA_W'(1) : '0;
            default: return '0;
        endcase
    endfunction

    forwarding_unit #(
        .REG_AW (REG_AW)
    ) u_fwd (
        .rs              (in_Rs_IDEX),
        .rt              (in_Rt_IDEX),
        .exmem_reg_write (out_reg_regWrite_EXMEM),
        .exmem_write_reg (out_reg_writeReg_EXMEM),
        .memwb_reg_write (regWrite_MEMWB),
        .memwb_write_reg (writeReg_MEMWB),
        .forward_a       (forward_a),
        .forward_b       (forward_b)
    );

    always_comb begin
        case (forward_a)
            FWD_EXMEM: op_a = out_reg_ALUres_EXMEM;
            FWD_MEMWB: op_a = writeData_MEMWB;
            default:   op_a = in_data1_IDEX;
        endcase
        case (forward_b)
            FWD_EXMEM: fwd_b = out_reg_ALUres_EXMEM;
            FWD_MEMWB: fwd_b = writeData_MEMWB;
            default:   fwd_b = in_data2_IDEX;
        endcase
        op_b      = in_ALUSrc_IDEX ? in_SEData_IDEX : fwd_b;
        alu_res   = alu_op(in_ALUop_IDEX, op_a, op_b);
        write_reg = in_regDst_IDEX ? in_Rd_IDEX : in_Rt_IDEX;
    end

    assign zero = (alu_res == '0);

    // EX/MEM boundary: loads every cycle, cleared by reset so an in-flight
    // instruction leaves no write enables behind.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_reg_regWrite_EXMEM  <= 1'b0;
            out_reg_memWrite_EXMEM  <= 1'b0;
            out_reg_memRead_EXMEM   <= 1'b0;
            out_reg_memtoReg_EXMEM  <= 1'b0;
            out_reg_ALUres_EXMEM    <= '0;
            out_reg_writeData_EXMEM <= '0;
            out_reg_writeReg_EXMEM  <= '0;
        end else begin
            out_reg_regWrite_EXMEM  <= in_regWrite_IDEX;
            out_reg_memWrite_EXMEM  <= in_memWrite_IDEX;
            out_reg_memRead_EXMEM   <= in_memRead_IDEX;
            out_reg_memtoReg_EXMEM  <= in_memtoReg_IDEX;
            out_reg_ALUres_EXMEM    <= alu_res;
            out_reg_writeData_EXMEM <= fwd_b;
            out_reg_writeReg_EXMEM  <= write_reg;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed scoreboard bench for ex_mem_stage: expected EX/MEM contents are
// queued as each instruction is driven and checked one edge later.
module tb_ex_mem_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_regWrite_IDEX, in_ALUSrc_IDEX, in_regDst_IDEX;
    logic        in_memWrite_IDEX, in_memRead_IDEX, in_memtoReg_IDEX;
    logic [2:0]  in_ALUop_IDEX;
    logic [4:0]  in_Rs_IDEX, in_Rt_IDEX, in_Rd_IDEX;
    logic [31:0] in_data1_IDEX, in_data2_IDEX, in_SEData_IDEX;
    logic        regWrite_MEMWB;
    logic [4:0]  writeReg_MEMWB;
    logic [31:0] writeData_MEMWB;
    logic        out_reg_regWrite_EXMEM, out_reg_memWrite_EXMEM;
    logic        out_reg_memRead_EXMEM, out_reg_memtoReg_EXMEM;
    logic [31:0] out_reg_ALUres_EXMEM, out_reg_writeData_EXMEM;
    logic [4:0]  out_reg_writeReg_EXMEM;
    logic        zero;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        logic        rw, mw, mr, mtr;
        logic [31:0] alu, wd;
        logic [4:0]  wr;
        bit          data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    ex_mem_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .in_regWrite_IDEX        (in_regWrite_IDEX),
        .in_ALUSrc_IDEX          (in_ALUSrc_IDEX),
        .in_regDst_IDEX          (in_regDst_IDEX),
        .in_memWrite_IDEX        (in_memWrite_IDEX),
        .in_memRead_IDEX         (in_memRead_IDEX),
        .in_memtoReg_IDEX        (in_memtoReg_IDEX),
        .in_ALUop_IDEX           (in_ALUop_IDEX),
        .in_Rs_IDEX              (in_Rs_IDEX),
        .in_Rt_IDEX              (in_Rt_IDEX),
        .in_Rd_IDEX              (in_Rd_IDEX),
        .in_data1_IDEX           (in_data1_IDEX),
        .in_data2_IDEX           (in_data2_IDEX),
        .in_SEData_IDEX          (in_SEData_IDEX),
        .regWrite_MEMWB          (regWrite_MEMWB),
        .writeReg_MEMWB          (writeReg_MEMWB),
        .writeData_MEMWB         (writeData_MEMWB),
        .out_reg_regWrite_EXMEM  (out_reg_regWrite_EXMEM),
        .out_reg_memWrite_EXMEM  (out_reg_memWrite_EXMEM),
        .out_reg_memRead_EXMEM   (out_reg_memRead_EXMEM),
        .out_reg_memtoReg_EXMEM  (out_reg_memtoReg_EXMEM),
        .out_reg_ALUres_EXMEM    (out_reg_ALUres_EXMEM),
        .out_reg_writeData_EXMEM (out_reg_writeData_EXMEM),
        .out_reg_writeReg_EXMEM  (out_reg_writeReg_EXMEM),
        .zero                    (zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ctl = {regWrite, ALUSrc, regDst, memWrite, memRead, memtoReg}
    task automatic issue(input logic [2:0] op, input logic [5:0] ctl,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] se);
        {in_regWrite_IDEX, in_ALUSrc_IDEX, in_regDst_IDEX,
         in_memWrite_IDEX, in_memRead_IDEX, in_memtoReg_IDEX} = ctl;
        in_ALUop_IDEX  = op;
        in_Rs_IDEX     = rs;
        in_Rt_IDEX     = rt;
        in_Rd_IDEX     = rd;
        in_data1_IDEX  = d1;
        in_data2_IDEX  = d2;
        in_SEData_IDEX = se;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] ctl,
                              input logic [31:0] alu, input logic [31:0] wd,
                              input logic [4:0] wr, input bit data);
        exp_t e;
        e.tag = tag;
        {e.rw, e.mw, e.mr, e.mtr} = ctl;
        e.alu = alu;
        e.wd = wd;
        e.wr = wr;
        e.data = data;
        sb.push_back(e);
    endtask

    // zexp < 0 skips the combinational zero check for this instruction.
    task automatic cycle(input int zexp);
        exp_t e;
        #1;
        if (zexp >= 0) chk("zero", {31'b0, zero}, {31'b0, zexp[0]});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".regWrite"}, {31'b0, out_reg_regWrite_EXMEM}, {31'b0, e.rw});
            chk({e.tag, ".memWrite"}, {31'b0, out_reg_memWrite_EXMEM}, {31'b0, e.mw});
            chk({e.tag, ".memRead"},  {31'b0, out_reg_memRead_EXMEM},  {31'b0, e.mr});
            chk({e.tag, ".memtoReg"}, {31'b0, out_reg_memtoReg_EXMEM}, {31'b0, e.mtr});
            if (e.data) begin
                chk({e.tag, ".ALUres"},    out_reg_ALUres_EXMEM, e.alu);
                chk({e.tag, ".writeData"}, out_reg_writeData_EXMEM, e.wd);
                chk({e.tag, ".writeReg"},  {27'b0, out_reg_writeReg_EXMEM}, {27'b0, e.wr});
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        regWrite_MEMWB  = 1'b0;
        writeReg_MEMWB  = 5'd0;
        writeData_MEMWB = 32'd0;
        @(negedge clk);

        // Reset with nonzero inputs, then release and load them.
        rst = 1'b0;
        issue(ALU_ADD, 6'b101111, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd9);
        expect_out("reset", 4'b0000, 32'd0, 32'd0, 5'd0, 1'b1);
        cycle(-1);
        rst = 1'b1;
        issue(ALU_ADD, 6'b101000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0);
        expect_out("add_nofwd", 4'b1000, 32'd12, 32'd7, 5'd3, 1'b1);
        cycle(0);

        // EX/MEM forwards 12 over stale data1=99.
        issue(ALU_SUB, 6'b101000, 5'd3, 5'd5, 5'd6, 32'd99, 32'd2, 32'd0);
        expect_out("sub_fwd_exmem", 4'b1000, 32'd10, 32'd2, 5'd6, 1'b1);
        cycle(0);

        // A write to $0 registers as-is but never forwards.
        issue(ALU_ADD, 6'b101000, 5'd1, 5'd2, 5'd0, 32'd5, 32'd7, 32'd0);
        expect_out("add_to_r0", 4'b1000, 32'd12, 32'd7, 5'd0, 1'b1);
        cycle(0);
        issue(ALU_SUB, 6'b101000, 5'd0, 5'd2, 5'd7, 32'd40, 32'd2, 32'd0);
        expect_out("sub_r0_nofwd", 4'b1000, 32'd38, 32'd2, 5'd7, 1'b1);
        cycle(0);

        // EX/MEM $4=20 beats MEM/WB $4=50 on both operands.
        issue(ALU_ADD, 6'b101000, 5'd1, 5'd2, 5'd4, 32'd15, 32'd5, 32'd0);
        expect_out("add_r4", 4'b1000, 32'd20, 32'd5, 5'd4, 1'b1);
        cycle(0);
        regWrite_MEMWB  = 1'b1;
        writeReg_MEMWB  = 5'd4;
        writeData_MEMWB = 32'd50;
        issue(ALU_OR, 6'b101000, 5'd4, 5'd4, 5'd8, 32'h111, 32'h111, 32'd0);
        expect_out("or_double_hazard", 4'b1000, 32'd20, 32'd20, 5'd8, 1'b1);
        cycle(0);

        // Store: address uses immediate, store data forwarded from MEM/WB.
        writeData_MEMWB = 32'hDEADBEEF;
        issue(ALU_ADD, 6'b010100, 5'd9, 5'd4, 5'd31, 32'd100, 32'd1, 32'd8);
        expect_out("sw_fwd_memwb", 4'b0100, 32'd108, 32'hDEADBEEF, 5'd4, 1'b1);
        cycle(0);
        regWrite_MEMWB = 1'b0;

        issue(ALU_SLT, 6'b101000, 5'd10, 5'd11, 5'd12, 32'hFFFFFFFF, 32'd1, 32'd0);
        expect_out("slt_neg_lt_pos", 4'b1000, 32'd1, 32'd1, 5'd12, 1'b1);
        cycle(0);
        issue(ALU_SLT, 6'b101000, 5'd13, 5'd14, 5'd15, 32'd1, 32'hFFFFFFFF, 32'd0);
        expect_out("slt_pos_lt_neg", 4'b1000, 32'd0, 32'hFFFFFFFF, 5'd15, 1'b1);
        cycle(1);

        // Bubble: control must clear, data is don't-care.
        issue(ALU_ADD, 6'b000000, 5'd1, 5'd2, 5'd3, 32'd3, 32'd4, 32'd0);
        expect_out("bubble", 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0);
        cycle(-1);

        issue(ALU_AND, 6'b101000, 5'd1, 5'd2, 5'd3, 32'h0000F0F0, 32'h0000FF00, 32'd0);
        expect_out("and", 4'b1000, 32'h0000F000, 32'h0000FF00, 5'd3, 1'b1);
        cycle(0);
        issue(3'b101, 6'b100000, 5'd20, 5'd21, 5'd22, 32'd5, 32'd7, 32'd0);
        expect_out("op101_zero", 4'b1000, 32'd0, 32'd7, 5'd21, 1'b1);
        cycle(1);

        // Reset drops an in-flight store/writeback.
        rst = 1'b0;
        issue(ALU_ADD, 6'b111101, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd9);
        expect_out("reset_inflight", 4'b0000, 32'd0, 32'd0, 5'd0, 1'b1);
        cycle(-1);
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
